// File: rtl/mlp_hls_deadlock_report_unit_if.sv
// Report channel from the deadlock report unit to the host (valid/ready).
interface mlp_hls_deadlock_report_unit_if #(
    parameter int unsigned PROC_NUM      = 4,
    parameter int unsigned TRACE_TIMEOUT = 64
);
    localparam int unsigned ID_W  = ($clog2(PROC_NUM) > 1) ? $clog2(PROC_NUM) : 1;
    localparam int unsigned CNT_W = $clog2(TRACE_TIMEOUT + 1);

    logic                report_valid;
    logic                report_ready;
    logic [ID_W-1:0]     report_origin;
    logic [PROC_NUM-1:0] report_path;
    logic [CNT_W-1:0]    report_len;
    logic                report_timeout;

    modport master (
        output report_valid, report_origin, report_path, report_len, report_timeout,
        input  report_ready
    );

    modport slave (
        input  report_valid, report_origin, report_path, report_len, report_timeout,
        output report_ready
    );
endinterface

// File: rtl/mlp_hls_deadlock_report_unit.sv
// Dataflow deadlock report controller: elects an origin, traces the token, reports to host.
// Optional MLP_HLS_DL_REARM_EN: return to IDLE after the report instead of halting.
module mlp_hls_deadlock_report_unit #(
    parameter int unsigned PROC_NUM      = 4,
    parameter int unsigned TRACE_TIMEOUT = 64
) (
    input  logic                reset,
    input  logic                clock,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    input  logic [PROC_NUM-1:0] token_seen_vec,
    output logic                dl_detect_bcast,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic                token_clear,
    output logic                deadlock_flag,
    mlp_hls_deadlock_report_unit_if.master rpt
);
    localparam int unsigned ID_W  = ($clog2(PROC_NUM) > 1) ? $clog2(PROC_NUM) : 1;
    localparam int unsigned CNT_W = $clog2(TRACE_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ORIGIN, TRACE, REPORT, HALT} state_t;

    state_t              state;
    logic [ID_W-1:0]     origin_id;
    logic [ID_W-1:0]     first_id;
    logic [PROC_NUM-1:0] path;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_inc;
    logic [CNT_W-1:0]    report_len;
    logic                report_valid;
    logic                report_timeout;
    logic                trace_return;
    logic                trace_expired;

    // Lowest-index detecting process wins the origin election.
    always_comb begin
        first_id = '0;
        for (int i = int'(PROC_NUM) - 1; i >= 0; i--) begin
            if (dl_detect_vec[i]) first_id = ID_W'(i);
        end
    end

    assign cnt_inc       = cnt + CNT_W'(1);
    assign trace_return  = (state == TRACE) && token_seen_vec[origin_id] && dl_detect_vec[origin_id];
    assign trace_expired = (cnt_inc == CNT_W'(TRACE_TIMEOUT));
    assign token_clear   = trace_return;

    assign rpt.report_valid   = report_valid;
    assign rpt.report_origin  = origin_id;
    assign rpt.report_path    = path;
    assign rpt.report_len     = report_len;
    assign rpt.report_timeout = report_timeout;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            origin_id       <= '0;
            path            <= '0;
            cnt             <= '0;
            report_len      <= '0;
            report_valid    <= 1'b0;
            report_timeout  <= 1'b0;
            dl_detect_bcast <= 1'b0;
            origin_vec      <= '0;
            deadlock_flag   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|dl_detect_vec) begin
                        origin_id       <= first_id;
                        origin_vec      <= PROC_NUM'(1) << first_id;
                        dl_detect_bcast <= 1'b1;
                        deadlock_flag   <= 1'b1;
                        state           <= ORIGIN;
                    end
                end
                ORIGIN: begin
                    origin_vec <= '0;
                    path       <= PROC_NUM'(1) << origin_id;
                    cnt        <= '0;
                    state      <= TRACE;
                end
                TRACE: begin
                    path <= path | token_seen_vec;
                    if (cnt != CNT_W'(TRACE_TIMEOUT)) cnt <= cnt_inc;
                    // A returning token beats the timeout on the same cycle.
                    if (trace_return) begin
                        report_len     <= cnt_inc;
                        report_timeout <= 1'b0;
                        report_valid   <= 1'b1;
                        state          <= REPORT;
                    end else if (trace_expired) begin
                        report_len     <= CNT_W'(TRACE_TIMEOUT);
                        report_timeout <= 1'b1;
                        report_valid   <= 1'b1;
                        state          <= REPORT;
                    end
                end
                REPORT: begin
                    if (rpt.report_ready) begin
                        report_valid <= 1'b0;
`ifdef MLP_HLS_DL_REARM_EN
                        dl_detect_bcast <= 1'b0;
                        path            <= '0;
                        report_len      <= '0;
                        state           <= IDLE;
`else
                        state <= HALT;
`endif
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/mlp_hls_deadlock_report_unit.md
# mlp_hls_deadlock_report_unit

Central controller at the other end of the per-process deadlock detection units in the MLP HLS dataflow region. Collects every unit's detect flag, elects one origin process, launches and traces the report token around the dependency cycle, clears it on return, and hands a single deadlock report to the host over a valid/ready interface. One instance per dataflow region.

## Interface
- PROC_NUM, 4, number of dataflow processes (≥2)
- TRACE_TIMEOUT, 64, max TRACE cycles before abandoning the trace (≥2)
- Derived: ID_W = max(1, $clog2(PROC_NUM)); CNT_W = $clog2(TRACE_TIMEOUT+1)

- reset  in  1  asynchronous, active-low
- clock  in  1  clock
- dl_detect_vec  in  PROC_NUM  bit p = dl_detect_out of process p's detect unit
- token_seen_vec  in  PROC_NUM  bit p = OR of process p's token_in_vec
- dl_detect_bcast  out  1  registered; drives every unit's dl_detect_in
- origin_vec  out  PROC_NUM  one-hot origin strobe, per-unit origin input
- token_clear  out  1  combinational; per-unit token_clear (same to all)
- report_valid  out  1  report available
- report_ready  in  1  host accepts report
- report_origin  out  ID_W  elected origin process index
- report_path  out  PROC_NUM  bitmap of processes the token visited (includes origin)
- report_len  out  CNT_W  TRACE cycles until return or timeout
- report_timeout  out  1  1 = token did not return within TRACE_TIMEOUT
- deadlock_flag  out  1  sticky, set on first detection

## Operation
- States: IDLE, ORIGIN, TRACE, REPORT, HALT. Outputs Moore-decoded except token_clear.
- IDLE: if |dl_detect_vec, latch origin id = lowest set index, set dl_detect_bcast and deadlock_flag, go ORIGIN. Else stay.
- ORIGIN (1 cycle): origin_vec = one-hot(id); path ← one-hot(id); cnt ← 0; go TRACE.
- TRACE: each cycle path |= token_seen_vec, cnt ← cnt+1 (saturating at TRACE_TIMEOUT).
  - Return: token_seen_vec[id] & dl_detect_vec[id] → token_clear=1 that same cycle; latch len=cnt+1, timeout=0; go REPORT.
  - Else if cnt+1 == TRACE_TIMEOUT → latch len=TRACE_TIMEOUT, timeout=1; go REPORT (no token_clear).
  - Return has priority over timeout in the same cycle.
- REPORT: report_valid=1; origin/path/len/timeout stable until report_ready sampled high; then go HALT.
- HALT: dl_detect_bcast stays 1, all strobes 0, inputs ignored.
- dl_detect_vec bits other than the origin's are ignored outside IDLE. report_ready with report_valid=0 ignored.
- token_clear is 0 in every state except the TRACE return cycle.

## Timing
- Reset values: dl_detect_bcast=0, origin_vec=0, token_clear=0, report_valid=0, report_origin=0, report_path=0, report_len=0, report_timeout=0, deadlock_flag=0; state IDLE.
- Detect sampled at edge T → ORIGIN during T+1 (origin_vec, dl_detect_bcast, deadlock_flag high); first TRACE cycle T+2; origin's neighbours see the token no earlier than T+2.
- Report latency: report_valid rises the cycle after the return/timeout cycle.
- Handshake transfer at the edge with report_valid & report_ready; report_valid low the next cycle.
- Reset asserted mid-operation: all state and outputs return to reset values asynchronously; trace abandoned, no report.

## Configuration
- MLP_HLS_DL_REARM_EN defined: after the report transfer go IDLE instead of HALT, clearing dl_detect_bcast and path/len; deadlock_flag stays sticky; a later detection starts a new trace.
- Undefined: HALT is terminal until reset.

## Test plan
- PROC_NUM=4; dl_detect_vec=0010 at T → origin_vec=0010 at T+1, dl_detect_bcast=1 from T+1, report_origin=1.
- Token visits 1→2→3→1: token_seen_vec 0100, 1000, then 0010 with dl_detect_vec[1]=1 → token_clear 1 for exactly that cycle, report_path=1110, report_len=3, report_timeout=0.
- dl_detect_vec=1010 simultaneously → origin 1 elected; later dl_detect_vec[3] ignored.
- No return, TRACE_TIMEOUT=64 → report_timeout=1, report_len=64, token_clear never asserted.
- report_ready held low 10 cycles → report fields stable, report_valid=1 throughout; ready high → one transfer, then HALT (or IDLE with MLP_HLS_DL_REARM_EN, second detection yields second report).
- Reset pulsed during TRACE → all outputs 0 immediately, no report after release.
